// File: rtl/t05_word_packer_pkg.sv
// Shared definitions for the t05 word packer: state codes, word geometry
// and the partial-word strobe lookup.
package t05_pkg;

    localparam int WORD_BYTES = 4;

    // State codes, kept as plain constants so legacy tooling can decode them.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_PACK  = 3'd1;
    localparam state_t S_FLUSH = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    // Strobe per number of filled lanes: slot 0 stands for four lanes (full
    // word), slots 1..3 set only the low lanes.
    localparam logic [15:0] SEL_LUT = {4'b0111, 4'b0011, 4'b0001, 4'b1111};

    // Lanes used (1..4) to byte strobes.
    function automatic logic [3:0] sel_for_fill(input logic [2:0] n);
        return SEL_LUT[{n[1:0], 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/t05_word_packer_fifo.sv
// Small word FIFO holding {sel, data} entries. A push into a full FIFO is
// taken only when a pop happens in the same cycle; otherwise it is refused
// and the caller decides what that means.
module t05_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because count guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/t05_word_packer.sv
// Byte-to-word packer: gathers bytes into 32-bit little-endian words,
// queues them and issues single-word writes with byte strobes. On flush the
// MSB-aligned remainder byte and any partial word are written out.
// Handshake: wr_req is high while a word is queued; wr_addr/wr_data/wr_sel
// hold steady until a cycle with wr_req & wr_ack, which retires the word.
// Optional macro T05_WORD_PACKER_BYTE_COUNT_EN adds the byte_count output.
module t05_word_packer
    import t05_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              flush_req,
    input  logic [6:0]        leftover_data,
    input  logic [2:0]        leftover_count,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_sel,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [2:0]        state_dbg
`ifdef T05_WORD_PACKER_BYTE_COUNT_EN
    ,
    output logic [15:0]       byte_count
`endif
);
    state_t            state;
    logic [1:0]        fill;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] addr_q;
    logic              overflow_q;

    logic [7:0]        rem_src;
    logic [7:0]        rem_byte;
    logic              ins_en;
    logic [7:0]        ins_byte;
    logic [31:0]       nxt_word;
    logic [2:0]        nxt_fill;
    logic              push;
    logic [35:0]       push_entry;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [35:0]       fifo_head;
    logic              arm;

    assign arm = en && start && (state == S_IDLE || state == S_DONE);

    // Remainder bits moved to the top of a byte; bits above the count fall off.
    assign rem_src  = {1'b0, leftover_data};
    assign rem_byte = rem_src << (4'd8 - {1'b0, leftover_count});

    // Lane insertion and push decision for the current cycle.
    always_comb begin
        ins_en     = 1'b0;
        ins_byte   = 8'h00;
        nxt_word   = word_q;
        nxt_fill   = {1'b0, fill};
        push       = 1'b0;
        push_entry = '0;
        if (en && state == S_PACK && byte_valid) begin
            ins_en   = 1'b1;
            ins_byte = byte_in;
        end else if (en && state == S_FLUSH && leftover_count != 3'd0) begin
            ins_en   = 1'b1;
            ins_byte = rem_byte;
        end
        if (ins_en) begin
            nxt_word[{fill, 3'b000} +: 8] = ins_byte;
            nxt_fill = {1'b0, fill} + 3'd1;
        end
        if (en && (nxt_fill == 3'd4 || (state == S_FLUSH && nxt_fill != 3'd0))) begin
            push       = 1'b1;
            push_entry = {sel_for_fill(nxt_fill), nxt_word};
        end
    end

    // An ack retires the head even while en is low.
    assign pop = !fifo_empty && wr_ack;

    t05_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (36)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Control state, word assembly, head address and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            fill       <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                addr_q <= addr_q + ADDR_W'(WORD_BYTES);
            end
            if (en) begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state      <= S_PACK;
                            addr_q     <= {base_addr[ADDR_W-1:2], 2'b00};
                            overflow_q <= 1'b0;
                            fill       <= '0;
                            word_q     <= '0;
                        end
                    end
                    S_PACK: begin
                        fill   <= nxt_fill[1:0];
                        word_q <= push ? 32'h0 : nxt_word;
                        if (flush_req) state <= S_FLUSH;
                    end
                    S_FLUSH: begin
                        fill   <= '0;
                        word_q <= '0;
                        state  <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (fifo_empty) state <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
                // A refused push loses the word; the address does not move.
                if (push && fifo_full && !pop) overflow_q <= 1'b1;
            end
        end
    end

`ifdef T05_WORD_PACKER_BYTE_COUNT_EN
    // Saturating count of bytes accepted into words, remainder included.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            byte_count <= '0;
        end else if (ins_en && byte_count != 16'hFFFF) begin
            byte_count <= byte_count + 16'd1;
        end
    end
`endif

    assign wr_req    = !fifo_empty;
    assign wr_addr   = addr_q;
    assign wr_data   = fifo_empty ? 32'h0 : fifo_head[31:0];
    assign wr_sel    = fifo_empty ? 4'h0 : fifo_head[35:32];
    assign busy      = (state == S_PACK) || (state == S_FLUSH) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign overflow  = overflow_q;
    assign state_dbg = state;

endmodule
